// File: rtl/filter_pkg.sv
// Shared types and helpers for the ping-pong filter weight memory.
// Packet layout on the NoC: {rsvd, dtype, dst, col, data}.
package filter_pkg;

  localparam int PKT_W = 32;

  localparam logic [1:0] DTYPE_DATA = 2'b00;
  localparam logic [1:0] DTYPE_CTRL = 2'b01;

  typedef struct packed {
    logic       rsvd;
    logic [1:0] dtype;
    logic [7:0] dst;
    logic [7:0] col;
    logic [12:0] data;
  } filter_pkt_t;

  typedef enum logic {S_IDLE, S_SEND} strm_state_e;

  function automatic filter_pkt_t make_filter_pkt(input logic [1:0] dtype,
                                                  input logic [7:0] dst,
                                                  input logic [7:0] col,
                                                  input logic [12:0] data);
    filter_pkt_t p;
    p.rsvd  = 1'b0;
    p.dtype = dtype;
    p.dst   = dst;
    p.col   = col;
    p.data  = data;
    return p;
  endfunction

endpackage

// File: rtl/filter_stream_fsm.sv
// Streamer for one full bank: walks rows/columns, replays cfg_repeat times,
// and pulses rel on the final handshake so the top can free the bank.
module filter_stream_fsm
  import filter_pkg::*;
#(
  parameter int         WIDTH_DATA = 13,
  parameter int         DEPTH_F    = 5,
  parameter int         WIDTH_F    = 5,
  parameter int         ADDR_W     = 5,
  parameter int         REP_W      = 4,
  parameter logic [1:0] DATA_TYPE  = 2'b00,
  parameter int         DST_BASE   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  full_rd,
  input  logic [REP_W-1:0]      cfg_repeat,
  input  logic                  out_ready,
  input  logic [WIDTH_DATA-1:0] rd_data,
  output logic [ADDR_W-1:0]     rd_idx,
  output logic                  out_valid,
  output logic [PKT_W-1:0]      out_pkt,
  output logic                  busy,
  output logic                  rel
);

  localparam int R_W = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;
  localparam int C_W = (WIDTH_F > 1) ? $clog2(WIDTH_F) : 1;

  strm_state_e      state, state_n;
  logic [R_W-1:0]   r;
  logic [C_W-1:0]   c;
  logic [REP_W-1:0] rep_left;
  logic             hs, row_end, last;

  assign hs      = (state == S_SEND) && out_ready;
  assign row_end = (c == C_W'(WIDTH_F - 1));
  assign last    = row_end && (r == R_W'(DEPTH_F - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (full_rd) state_n = S_SEND;
      S_SEND: if (hs && last && rep_left == '0) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Replays wrap straight back to element 0 so passes run without a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r        <= '0;
      c        <= '0;
      rep_left <= '0;
    end else if (state == S_IDLE && full_rd) begin
      r        <= '0;
      c        <= '0;
      rep_left <= cfg_repeat;
    end else if (hs) begin
      if (!row_end) begin
        c <= c + 1'b1;
      end else begin
        c <= '0;
        if (!last) begin
          r <= r + 1'b1;
        end else begin
          r <= '0;
          if (rep_left != '0) rep_left <= rep_left - 1'b1;
        end
      end
    end
  end

  always_comb begin
    out_valid = (state == S_SEND);
    busy      = (state == S_SEND);
    rel       = hs && last && (rep_left == '0);
    rd_idx    = ADDR_W'(r) * ADDR_W'(WIDTH_F) + ADDR_W'(c);
    out_pkt   = '0;
    if (state == S_SEND)
      out_pkt = make_filter_pkt(DATA_TYPE, 8'(DST_BASE) + 8'(r), 8'(c), 13'(rd_data));
  end

endmodule

// File: rtl/filter_mem_pp.sv
// Double-buffered filter weight memory: one bank loads through the write
// port while the other streams to the PE columns as NoC packets.
module filter_mem_pp
  import filter_pkg::*;
#(
  parameter int         WIDTH_DATA = 13,
  parameter int         DEPTH_F    = 5,
  parameter int         WIDTH_F    = 5,
  parameter int         N_ELEM     = DEPTH_F * WIDTH_F,
  parameter int         ADDR_W     = (N_ELEM > 1) ? $clog2(N_ELEM) : 1,
  parameter logic [1:0] DATA_TYPE  = 2'b00,
  parameter int         DST_BASE   = 0,
  parameter int         REP_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [WIDTH_DATA-1:0] wr_data,
  input  logic [REP_W-1:0]      cfg_repeat,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PKT_W-1:0]      out_pkt,
  output logic [1:0]            bank_full,
  output logic                  busy,
  output logic                  err_addr
);

  localparam int CNT_W = $clog2(N_ELEM + 1);

  logic [WIDTH_DATA-1:0] mem [2][N_ELEM];
  logic                  load_ptr, rd_ptr;
  logic [CNT_W-1:0]      wr_cnt;
  logic [1:0]            full_n;
  logic                  wr_fire, addr_ok, load_done, rel;
  logic [ADDR_W-1:0]     rd_idx;
  logic [WIDTH_DATA-1:0] rd_data;

  assign wr_ready  = !bank_full[load_ptr];
  assign wr_fire   = wr_valid && wr_ready;
  assign addr_ok   = {1'b0, wr_addr} < (ADDR_W + 1)'(N_ELEM);
  // Completion counts accepted writes, so a dropped bad address still counts.
  assign load_done = wr_fire && (wr_cnt == CNT_W'(N_ELEM - 1));
  assign rd_data   = mem[rd_ptr][rd_idx];

  always_ff @(posedge clk) begin
    if (wr_fire && addr_ok) mem[load_ptr][wr_addr] <= wr_data;
  end

  // Release and load completion always hit different banks, so both apply.
  always_comb begin
    full_n = bank_full;
    if (rel)       full_n[rd_ptr]   = 1'b0;
    if (load_done) full_n[load_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_full <= '0;
      load_ptr  <= 1'b0;
      rd_ptr    <= 1'b0;
      wr_cnt    <= '0;
      err_addr  <= 1'b0;
    end else begin
      bank_full <= full_n;
      if (rel) rd_ptr <= ~rd_ptr;
      if (wr_fire) begin
        if (!addr_ok) err_addr <= 1'b1;
        if (load_done) begin
          wr_cnt   <= '0;
          load_ptr <= ~load_ptr;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end
    end
  end

  filter_stream_fsm #(
    .WIDTH_DATA(WIDTH_DATA),
    .DEPTH_F   (DEPTH_F),
    .WIDTH_F   (WIDTH_F),
    .ADDR_W    (ADDR_W),
    .REP_W     (REP_W),
    .DATA_TYPE (DATA_TYPE),
    .DST_BASE  (DST_BASE)
  ) u_fsm (
    .clk       (clk),
    .rst_n     (rst_n),
    .full_rd   (bank_full[rd_ptr]),
    .cfg_repeat(cfg_repeat),
    .out_ready (out_ready),
    .rd_data   (rd_data),
    .rd_idx    (rd_idx),
    .out_valid (out_valid),
    .out_pkt   (out_pkt),
    .busy      (busy),
    .rel       (rel)
  );

endmodule

// File: tb/tb_filter_mem_pp.sv
// Bench for filter_mem_pp: scenario tasks against a filter-level model that
// tracks bank contents and the expected packet sequence.
module tb_filter_mem_pp;

  localparam int N = 25;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid;
  logic        wr_ready;
  logic [4:0]  wr_addr;
  logic [12:0] wr_data;
  logic [3:0]  cfg_repeat;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pkt;
  logic [1:0]  bank_full;
  logic        busy;
  logic        err_addr;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [31:0] got[$];
  int          got_t[$];
  logic [31:0] expq[$];
  int          model_mem[2][N];
  int          lp;
  int          wcnt;
  int          exp_rep;

  filter_mem_pp dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .cfg_repeat(cfg_repeat),
    .out_valid(out_valid), .out_ready(out_ready), .out_pkt(out_pkt),
    .bank_full(bank_full), .busy(busy), .err_addr(err_addr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      got.push_back(out_pkt);
      got_t.push_back(cyc);
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; wr_valid = 1'b0; out_ready = 1'b0; cfg_repeat = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lp = 0; wcnt = 0; expq.delete();
  endtask

  // One write; on the filter's last accepted word, append its expected packets.
  task automatic wr(input int a, input int d, output int waits);
    waits = 0;
    wr_valid = 1'b1; wr_addr = 5'(a); wr_data = 13'(d);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (wr_ready) break;
      waits++;
    end
    if (waits >= 3000) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_timeout: addr %0d never accepted, wr_ready stuck at %0b, need 1", a, wr_ready);
      wr_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    if (a < N) model_mem[lp][a] = d;
    wcnt++;
    if (wcnt == N) begin
      wcnt = 0;
      for (int p = 0; p <= exp_rep; p++)
        for (int r = 0; r < 5; r++)
          for (int c = 0; c < 5; c++)
            expq.push_back({1'b0, 2'b00, 8'(r), 8'(c), 13'(model_mem[lp][r*5+c])});
      lp ^= 1;
    end
  endtask

  task automatic load_vals(input int v[N], output int tot_waits);
    int w;
    tot_waits = 0;
    for (int a = 0; a < N; a++) begin
      wr(a, v[a], w);
      tot_waits += w;
    end
  endtask

  task automatic rand_vals(output int v[N]);
    for (int i = 0; i < N; i++) v[i] = int'($urandom_range(0, 8191));
  endtask

  task automatic check_stream(input string nm, input int base);
    int need;
    need = expq.size();
    for (int i = 0; i < 3000 && (got.size() - base) < need; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    n_cmp++;
    if (got.size() - base !== need) begin
      n_bad++;
      $display("FAIL %s_count: got %0d packets, need %0d", nm, got.size() - base, need);
    end
    for (int i = 0; i < need && base + i < got.size(); i++) begin
      n_cmp++;
      if (got[base+i] !== expq[i]) begin
        n_bad++;
        $display("FAIL %s_pkt%0d: got %h, need %h", nm, i, got[base+i], expq[i]);
      end
    end
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (out_valid !== 1'b0)    begin n_bad++; $display("FAIL rst_out_valid: got %b need 0", out_valid); end
    n_cmp++; if (out_pkt !== 32'h0)     begin n_bad++; $display("FAIL rst_out_pkt: got %h need 0", out_pkt); end
    n_cmp++; if (bank_full !== 2'b00)   begin n_bad++; $display("FAIL rst_bank_full: got %b need 00", bank_full); end
    n_cmp++; if (busy !== 1'b0)         begin n_bad++; $display("FAIL rst_busy: got %b need 0", busy); end
    n_cmp++; if (err_addr !== 1'b0)     begin n_bad++; $display("FAIL rst_err_addr: got %b need 0", err_addr); end
    n_cmp++; if (wr_ready !== 1'b1)     begin n_bad++; $display("FAIL rst_wr_ready: got %b need 1", wr_ready); end
  endtask

  task automatic test_single();
    int v[N], w, base;
    do_reset();
    out_ready = 1'b1; exp_rep = 0; base = got.size();
    for (int i = 0; i < N; i++) v[i] = i + 1;
    load_vals(v, w);
    @(negedge clk);
    n_cmp++; if (bank_full[0] !== 1'b1) begin n_bad++; $display("FAIL single_full0: got %b need 1", bank_full[0]); end
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency: out_valid %b need 1", out_valid); end
    check_stream("single", base);
    n_cmp++; if (got[base] !== 32'h0000_0001) begin n_bad++; $display("FAIL single_pkt0: got %h need 00000001", got[base]); end
    n_cmp++; if (got[base+7] !== {1'b0, 2'b00, 8'd1, 8'd2, 13'd8}) begin
      n_bad++; $display("FAIL single_pkt7: got %h need %h", got[base+7], {1'b0, 2'b00, 8'd1, 8'd2, 13'd8});
    end
    n_cmp++; if (bank_full !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL single_idle: bank_full=%b busy=%b, need 00/0", bank_full, busy);
    end
  endtask

  task automatic test_backpressure();
    int v[N], w, base;
    logic ph;
    logic [31:0] pp;
    do_reset();
    out_ready = 1'b0; exp_rep = 0; base = got.size(); ph = 1'b0; pp = '0;
    rand_vals(v);
    load_vals(v, w);
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (ph) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_pkt !== pp) begin
          n_bad++;
          $display("FAIL bp_stable: valid=%b pkt=%h, need 1/%h", out_valid, out_pkt, pp);
        end
      end
      ph = out_valid && !out_ready;
      pp = out_pkt;
      @(posedge clk); #1;
      out_ready = ~out_ready;
    end
    out_ready = 1'b1;
    check_stream("bp", base);
  endtask

  task automatic test_repeat();
    int v[N], w, base;
    do_reset();
    out_ready = 1'b1; cfg_repeat = 4'd2; exp_rep = 2; base = got.size();
    rand_vals(v);
    load_vals(v, w);
    for (int i = 0; i < 100 && got.size() <= base; i++) @(posedge clk);
    #1 cfg_repeat = 4'($urandom_range(3, 15));
    check_stream("repeat", base);
    if (got.size() >= base + 75) begin
      n_cmp++;
      if (got_t[base+74] - got_t[base] !== 74) begin
        n_bad++;
        $display("FAIL repeat_bubble: span %0d cycles, need 74", got_t[base+74] - got_t[base]);
      end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL repeat_busy: got %b need 0", busy); end
    cfg_repeat = '0;
  endtask

  task automatic test_ping_pong();
    int va[N], vb[N], vc[N], wa, wb, wc, base;
    do_reset();
    out_ready = 1'b0; exp_rep = 0; base = got.size();
    for (int i = 0; i < N; i++) begin va[i] = i + 1; vb[i] = i + 101; end
    rand_vals(vc);
    load_vals(va, wa);
    load_vals(vb, wb);
    n_cmp++; if (wb !== 0) begin n_bad++; $display("FAIL pp_b_stall: B waited %0d cycles, need 0", wb); end
    @(negedge clk);
    n_cmp++; if (bank_full !== 2'b11 || wr_ready !== 1'b0) begin
      n_bad++; $display("FAIL pp_both_full: bank_full=%b wr_ready=%b, need 11/0", bank_full, wr_ready);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    load_vals(vc, wc);
    n_cmp++; if (wc < 20) begin n_bad++; $display("FAIL pp_c_stall: C waited %0d cycles, need >=20", wc); end
    check_stream("pp", base);
  endtask

  task automatic test_bad_addr();
    int v1[N], v2[N], v3[N], w, base;
    do_reset();
    out_ready = 1'b1; exp_rep = 0; base = got.size();
    rand_vals(v1); rand_vals(v2); rand_vals(v3);
    load_vals(v1, w);
    load_vals(v2, w);
    n_cmp++; if (err_addr !== 1'b0) begin n_bad++; $display("FAIL bad_pre: err_addr %b need 0", err_addr); end
    for (int a = 0; a < N; a++) begin
      if (a == 13) wr(30, v3[a], w);
      else         wr(a, v3[a], w);
      if (a == 13) begin
        n_cmp++; if (err_addr !== 1'b1) begin n_bad++; $display("FAIL bad_set: err_addr %b need 1", err_addr); end
      end
    end
    check_stream("bad", base);
    n_cmp++; if (err_addr !== 1'b1) begin n_bad++; $display("FAIL bad_sticky: err_addr %b need 1", err_addr); end
  endtask

  task automatic test_reset_mid();
    int v[N], w, base;
    do_reset();
    out_ready = 1'b1; exp_rep = 0; base = got.size();
    rand_vals(v);
    load_vals(v, w);
    for (int i = 0; i < 200 && (got.size() - base) < 10; i++) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || bank_full !== 2'b00 || busy !== 1'b0) begin
      n_bad++; $display("FAIL mid_reset: valid=%b full=%b busy=%b, need 0/00/0", out_valid, bank_full, busy);
    end
    n_cmp++; if (got.size() - base !== 10) begin n_bad++; $display("FAIL mid_count: got %0d need 10", got.size() - base); end
    for (int i = 0; i < 10 && base + i < got.size(); i++) begin
      n_cmp++;
      if (got[base+i] !== expq[i]) begin n_bad++; $display("FAIL mid_pkt%0d: got %h need %h", i, got[base+i], expq[i]); end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lp = 0; wcnt = 0; expq.delete(); base = got.size();
    rand_vals(v);
    load_vals(v, w);
    check_stream("mid_reload", base);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    cfg_repeat = '0; out_ready = 1'b0; lp = 0; wcnt = 0; exp_rep = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_repeat();
    test_ping_pong();
    test_bad_addr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
